// File: rtl/adder_tree_feeder_pkg.sv
// Shared types and helpers for the adder-tree feeder and its pipelined tree.
// Holds the group descriptor carried alongside data through the pipeline.
package adder_tree_feeder_pkg;

  // Wide enough for any practical group size; narrowed to the real count width at the output.
  localparam int DESC_COUNT_W = 16;

  typedef struct packed {
    logic                    valid;
    logic [DESC_COUNT_W-1:0] count;
  } group_desc_t;

  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Bit offset of tree level s inside a flat vector where level t has n>>t nodes of width iw+t.
  function automatic int level_offset(input int n, input int iw, input int s);
    int off;
    off = 0;
    for (int t = 0; t < s; t++) begin
      off += (n >> t) * (iw + t);
    end
    return off;
  endfunction

endpackage

// File: rtl/pipelined_adder_tree.sv
// Binary reduction tree with one register level per stage, all levels gated by advance.
// Each stage output is one bit wider than its inputs, so sums are exact.
module pipelined_adder_tree
  import adder_tree_feeder_pkg::*;
#(
  parameter int NUM_INPUTS  = 8,
  parameter int INPUT_SIZE  = 12,
  parameter int NUM_STAGES  = $clog2(NUM_INPUTS),
  parameter int OUTPUT_SIZE = INPUT_SIZE + NUM_STAGES
) (
  input  logic                             clk,
  input  logic                             advance,
  input  logic [NUM_INPUTS*INPUT_SIZE-1:0] in_data,
  output logic [OUTPUT_SIZE-1:0]           out_data
);

  localparam int TOTAL_BITS = level_offset(NUM_INPUTS, INPUT_SIZE, NUM_STAGES + 1);
  localparam int FINAL_W    = INPUT_SIZE + NUM_STAGES;

  // All levels packed into one vector; level 0 is the raw group.
  logic [TOTAL_BITS-1:0] lvl_bits;

  assign lvl_bits[NUM_INPUTS*INPUT_SIZE-1:0] = in_data;

  generate
    for (genvar gs = 0; gs < NUM_STAGES; gs++) begin : g_stage
      localparam int SRC_W   = INPUT_SIZE + gs;
      localparam int DST_W   = INPUT_SIZE + gs + 1;
      localparam int SRC_OFF = level_offset(NUM_INPUTS, INPUT_SIZE, gs);
      localparam int DST_OFF = level_offset(NUM_INPUTS, INPUT_SIZE, gs + 1);
      localparam int NODES   = NUM_INPUTS >> (gs + 1);

      for (genvar gi = 0; gi < NODES; gi++) begin : g_node
        logic [DST_W-1:0] sum_reg;

        always_ff @(posedge clk) begin
          if (advance) begin
            sum_reg <= {1'b0, lvl_bits[SRC_OFF + (2*gi)*SRC_W +: SRC_W]}
                     + {1'b0, lvl_bits[SRC_OFF + (2*gi+1)*SRC_W +: SRC_W]};
          end
        end

        assign lvl_bits[DST_OFF + gi*DST_W +: DST_W] = sum_reg;
      end
    end
  endgenerate

  assign out_data = OUTPUT_SIZE'(lvl_bits[TOTAL_BITS-1 -: FINAL_W]);

endmodule

// File: rtl/adder_tree_feeder.sv
// Packs a stream of elements into fixed-size groups (closed early by in_last)
// and feeds them into a pipelined adder tree with valid/ready on both sides.
module adder_tree_feeder
  import adder_tree_feeder_pkg::*;
#(
  parameter int NUM_INPUTS  = 8,
  parameter int INPUT_SIZE  = 12,
  parameter int NUM_STAGES  = $clog2(NUM_INPUTS),
  parameter int OUTPUT_SIZE = INPUT_SIZE + NUM_STAGES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INPUT_SIZE-1:0]            in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUTPUT_SIZE-1:0]           out_data,
  output logic [count_width(NUM_INPUTS)-1:0] out_count
);

  localparam int CW = count_width(NUM_INPUTS);

  logic [INPUT_SIZE-1:0] grp_reg  [NUM_INPUTS];
  logic [INPUT_SIZE-1:0] grp_next [NUM_INPUTS];
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic                  closed_reg, closed_next;
  group_desc_t           desc_reg [NUM_STAGES];
  group_desc_t           desc_in;

  logic                  stall, advance, issue, accept;
  logic [CW-1:0]         slot;
  logic [NUM_INPUTS*INPUT_SIZE-1:0] tree_in;
  logic [OUTPUT_SIZE-1:0]           tree_sum;

  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign issue    = closed_reg && advance;
  // A closed group that is issuing frees the register, so the next element can land in slot 0.
  assign in_ready = !closed_reg || issue;
  assign accept   = in_valid && in_ready;

  always_comb begin
    grp_next    = grp_reg;
    cnt_next    = cnt_reg;
    closed_next = closed_reg;
    slot        = issue ? '0 : cnt_reg;

    if (issue) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        grp_next[i] = '0;
      end
      cnt_next    = '0;
      closed_next = 1'b0;
    end

    if (accept) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (CW'(i) == slot) begin
          grp_next[i] = in_data;
        end
      end
      cnt_next    = slot + 1'b1;
      closed_next = in_last || (slot == CW'(NUM_INPUTS - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      closed_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      closed_reg <= closed_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          grp_reg[gi] <= '0;
        end else begin
          grp_reg[gi] <= grp_next[gi];
        end
      end
      assign tree_in[gi*INPUT_SIZE +: INPUT_SIZE] = grp_reg[gi];
    end
  endgenerate

  // Bubbles enter as an all-zero descriptor.
  always_comb begin
    desc_in = '0;
    if (issue) begin
      desc_in.valid = 1'b1;
      desc_in.count = DESC_COUNT_W'(cnt_reg);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_desc
      always_ff @(posedge clk) begin
        if (rst) begin
          desc_reg[gi] <= '0;
        end else if (advance) begin
          if (gi == 0) begin
            desc_reg[gi] <= desc_in;
          end else begin
            desc_reg[gi] <= desc_reg[(gi == 0) ? 0 : gi-1];
          end
        end
      end
    end
  endgenerate

  pipelined_adder_tree #(
    .NUM_INPUTS  (NUM_INPUTS),
    .INPUT_SIZE  (INPUT_SIZE),
    .NUM_STAGES  (NUM_STAGES),
    .OUTPUT_SIZE (OUTPUT_SIZE)
  ) u_tree (
    .clk      (clk),
    .advance  (advance),
    .in_data  (tree_in),
    .out_data (tree_sum)
  );

  assign out_valid = desc_reg[NUM_STAGES-1].valid;
  assign out_count = out_valid ? CW'(desc_reg[NUM_STAGES-1].count) : '0;
  assign out_data  = out_valid ? tree_sum : '0;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed bench for adder_tree_feeder: a group-sum scoreboard model plus hand-computed expectations.
module tb_adder_tree_feeder;

  localparam int N  = 8;
  localparam int IW = 12;
  localparam int S  = 3;
  localparam int OW = 15;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [IW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  adder_tree_feeder #(
    .NUM_INPUTS  (N),
    .INPUT_SIZE  (IW),
    .NUM_STAGES  (S),
    .OUTPUT_SIZE (OW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_sum[$];
  int exp_cnt[$];
  int got_sum[$];
  int got_cnt[$];
  int first_valid_cyc = -1;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Model: sum accepted elements; a group ends at the N-th element or at in_last.
  initial begin
    int part_sum;
    int part_cnt;
    part_sum = 0;
    part_cnt = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        part_sum = 0;
        part_cnt = 0;
        exp_sum.delete();
        exp_cnt.delete();
      end else if (in_valid && in_ready) begin
        part_sum += int'(in_data);
        part_cnt++;
        if (in_last || part_cnt == N) begin
          exp_sum.push_back(part_sum);
          exp_cnt.push_back(part_cnt);
          part_sum = 0;
          part_cnt = 0;
        end
      end
    end
  end

  // Per-cycle output compare.
  initial begin
    bit prev_stall;
    int prev_data;
    int prev_count;
    int e_sum;
    int e_cnt;
    prev_stall = 1'b0;
    prev_data  = 0;
    prev_count = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_data", int'(out_data), prev_data);
          check("hold_count", int'(out_count), prev_count);
        end
        if (out_valid) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (out_ready) begin
            if (exp_sum.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_output: got sum %0d count %0d, model has no pending group", out_data, out_count);
            end else begin
              e_sum = exp_sum.pop_front();
              e_cnt = exp_cnt.pop_front();
              check("sum", int'(out_data), e_sum);
              check("count", int'(out_count), e_cnt);
              $display("out: sum=%0d count=%0d (cycle %0d)", out_data, out_count, cyc);
            end
            got_sum.push_back(int'(out_data));
            got_cnt.push_back(int'(out_count));
          end
        end else begin
          check("idle_data", int'(out_data), 0);
          check("idle_count", int'(out_count), 0);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = int'(out_data);
        prev_count = int'(out_count);
      end
    end
  end

  task automatic send(input int d, input bit last, output int waited);
    in_valid = 1'b1;
    in_data  = IW'(d);
    in_last  = last;
    waited   = 0;
    while (1) begin
      @(posedge clk);
      waited++;
      if (in_ready) break;
      if (waited > 60) begin
        check("send_timeout", waited, 0);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int k;
    k = 0;
    while (got_sum.size() < n && k < 80) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    check("num_outputs", got_sum.size(), n);
    #1;
  endtask

  task automatic clear_log();
    got_sum.delete();
    got_cnt.delete();
    first_valid_cyc = -1;
  endtask

  initial begin
    int w;
    int issue_cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_count", int'(out_count), 0);
    @(posedge clk);
    #1;

    // 1..8 back-to-back; issue happens in the cycle after the closing element.
    clear_log();
    for (int i = 1; i <= N; i++) send(i, 1'b0, w);
    issue_cyc = cyc + 1;
    wait_outs(1);
    if (got_sum.size() >= 1) begin
      check("t1_sum", got_sum[0], 36);
      check("t1_count", got_cnt[0], 8);
    end
    check("t1_latency", first_valid_cyc - issue_cyc, S);

    // Short group closed by in_last.
    clear_log();
    send(4095, 1'b0, w);
    send(4095, 1'b0, w);
    send(4095, 1'b1, w);
    wait_outs(1);
    if (got_sum.size() >= 1) begin
      check("t2_sum", got_sum[0], 12285);
      check("t2_count", got_cnt[0], 3);
    end

    // Full-scale group, no truncation.
    clear_log();
    for (int i = 0; i < N; i++) send(4095, 1'b0, w);
    wait_outs(1);
    if (got_sum.size() >= 1) begin
      check("t3_sum", got_sum[0], 32760);
      check("t3_count", got_cnt[0], 8);
    end

    // Two full groups under backpressure.
    clear_log();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(1, 1'b0, w);
    for (int i = 0; i < N; i++) send(2, 1'b0, w);
    begin
      int k;
      k = 0;
      while (!out_valid && k < 40) begin
        @(negedge clk);
        k++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_in_ready", int'(in_ready), 0);
      check("t4_stall_data", int'(out_data), 8);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_outs(2);
    if (got_sum.size() >= 2) begin
      check("t4_first", got_sum[0], 8);
      check("t4_second", got_sum[1], 16);
      check("t4_count", got_cnt[1], 8);
    end

    // Reset mid-group discards the partial group.
    clear_log();
    for (int i = 0; i < 5; i++) send(100, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= N; i++) send(i, 1'b0, w);
    wait_outs(1);
    if (got_sum.size() >= 1) begin
      check("t5_sum", got_sum[0], 36);
      check("t5_count", got_cnt[0], 8);
    end

    // in_last on the 8th slot, then a new group immediately.
    clear_log();
    for (int i = 1; i <= N; i++) send(i, (i == N), w);
    send(10, 1'b0, w);
    check("t6_no_dead_cycle", w, 1);
    send(20, 1'b0, w);
    send(30, 1'b1, w);
    wait_outs(2);
    if (got_sum.size() >= 2) begin
      check("t6_first_sum", got_sum[0], 36);
      check("t6_first_count", got_cnt[0], 8);
      check("t6_second_sum", got_sum[1], 60);
      check("t6_second_count", got_cnt[1], 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_tree_feeder.md
ADDER_TREE_FEEDER -- requirements
Module: adder_tree_feeder

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 8, elements per reduction group; power of two, >= 2.
REQ-002 SHALL have parameter INPUT_SIZE, default 12, unsigned element width.
REQ-003 SHALL have parameter NUM_STAGES, default $clog2(NUM_INPUTS), tree depth and pipeline latency.
REQ-004 SHALL have parameter OUTPUT_SIZE, default INPUT_SIZE+NUM_STAGES, sum width.
REQ-005 SHALL have ports clk (input, 1, sole clock) and rst (input, 1); reset is synchronous and active-high.
REQ-006 SHALL have port in_valid (input, 1), element offered.
REQ-007 SHALL have port in_ready (output, 1), element accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data (input, INPUT_SIZE), element value.
REQ-009 SHALL have port in_last (input, 1), closes the current group with this element.
REQ-010 SHALL have port out_valid (output, 1), sum available.
REQ-011 SHALL have port out_ready (input, 1), sum consumed when out_valid && out_ready.
REQ-012 SHALL have port out_data (output, OUTPUT_SIZE), group sum.
REQ-013 SHALL have port out_count (output, $clog2(NUM_INPUTS)+1), number of real elements in the group.

Function
REQ-014 Accepted elements SHALL fill group slots 0..NUM_INPUTS-1 in arrival order; unfilled slots SHALL hold zero.
REQ-015 A group SHALL close when slot NUM_INPUTS-1 is filled or an element with in_last=1 is accepted; in_last on the final slot closes exactly one group.
REQ-016 stall = out_valid && !out_ready; advance = !stall; the tree, the valid shift register and the count shift register SHALL move only on advance.
REQ-017 A closed group SHALL be issued into tree stage 0 on the first cycle with advance=1; the issue register then clears to zeros with count 0.
REQ-018 in_ready SHALL be 1 when the group is open, or when it is closed and issuing this cycle (element goes to slot 0 of the next group); otherwise 0.
REQ-019 Without stalls, out_valid SHALL rise exactly NUM_STAGES cycles after the issue edge; sustained throughput one element per cycle.
REQ-020 out_valid SHALL equal the last valid-shift-register bit; out_count SHALL travel in lockstep with its group.
REQ-021 Sums SHALL be exact unsigned, zero-extended per stage, no overflow (width INPUT_SIZE+stage+1 at stage outputs).
REQ-022 out_data and out_count SHALL be driven 0 whenever out_valid=0.
REQ-023 While stalled, out_valid/out_data/out_count SHALL hold stable and no in-flight group SHALL be lost or reordered.
REQ-024 Bubbles (no group to issue on advance) SHALL enter the valid shift register as 0.

Reset
REQ-025 On rst=1 at a clk edge: slot counter 0, group register zeros, closed flag 0, valid and count shift registers 0; rst overrides all other events, including mid-group and mid-stall.
REQ-026 After reset: in_ready=1, out_valid=0, out_data=0, out_count=0; tree data registers need no reset (masked by REQ-022).

Structure
REQ-027 A shared package SHALL hold the count-width function and a group-descriptor struct (count plus valid flag) used by the shift registers.
REQ-028 SHALL instantiate pipelined_adder_tree as its single sub-module, driving its advance and data inputs; all control logic stays in this module.

Verification (NUM_INPUTS=8, INPUT_SIZE=12, OUTPUT_SIZE=15)
REQ-029 Elements 1..8 back-to-back, out_ready=1 -> out_data=36, out_count=8, out_valid exactly 3 cycles after issue.
REQ-030 4095,4095,4095 with in_last on third -> out_data=12285, out_count=3.
REQ-031 Eight elements of 4095 -> out_data=32760 exact, no truncation.
REQ-032 Two full groups (all 1s, all 2s) with out_ready=0 for 5 cycles -> out_data 8 held stable, then 16; no loss, order kept, in_ready drops when the pipeline is full.
REQ-033 rst after 5 accepted elements, then 1..8 -> only one output, 36, count 8.
REQ-034 in_last on 8th element followed immediately by new elements -> one output with count 8, no empty group; next group starts at slot 0 with no dead cycle.
